// File: rtl/if_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_stage_pkg
// Shared pipeline definitions for the instruction fetch stage:
//   - fetch controller state encoding (FETCH / BUFFERED / DISCARD)
//   - NOP_INST, the instruction word presented for a pipeline bubble
//   - DEFAULT_RESET_PC, the default first fetch address after reset
//   - word_align(), which clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package if_stage_pkg;

    // Request outstanding at PC.
    localparam logic [1:0] ST_FETCH    = 2'd0;
    // Response held in the skid buffer while ID is stalled; no request.
    localparam logic [1:0] ST_BUFFERED = 2'd1;
    // Wrong-path request still outstanding; its response is thrown away.
    localparam logic [1:0] ST_DISCARD  = 2'd2;

    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Instruction addresses are word aligned; the byte offset is dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction fetch stage. Issues word requests to instruction memory,
// absorbs variable memory latency and ID-stage stalls with a one-entry skid
// buffer, and squashes wrong-path fetches when ID resolves a branch/jump.
//
// Ports
//   clk              sole clock, all state updates on the rising edge
//   rst              synchronous active-high reset
//   stall            hazard-unit hold; IF/ID outputs keep their values
//   redirect_valid   one-cycle pulse, branch/jump resolved in ID
//   redirect_target  new fetch address (byte offset ignored)
//   imem_req         instruction memory request
//   imem_addr        request address, stable until imem_ready
//   imem_ready       response accepted, imem_rdata valid this cycle
//   imem_rdata       fetched instruction word
//   PCAdd4           registered address of presented instruction plus 4
//   Inst             registered instruction, NOP_INST for a bubble
//   inst_valid       registered, 1 when Inst is a real fetched instruction
// ---------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCAdd4,
    output logic [31:0] Inst,
    output logic        inst_valid
);

    logic [1:0]  state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] stale_addr;
    logic [31:0] buf_inst;
    logic [31:0] buf_pcadd4;

    // Wraps modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
    assign pc_plus4 = pc + 32'd4;

    // The request is gated by rst so memory sees no request during reset,
    // which also abandons whatever was in flight. BUFFERED is the only state
    // without a request. While draining a wrong-path request the address must
    // stay at the stale value until memory accepts it; PC already holds the
    // redirect target by then.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        if (!rst) begin
            imem_req = (state != ST_BUFFERED);
        end
        if (state == ST_DISCARD) begin
            imem_addr = stale_addr;
        end
    end

    // Fetch controller and IF/ID output registers. Priority is reset, then
    // redirect, then normal fetch/stall behaviour. Being in BUFFERED is what
    // marks the skid buffer as holding a valid entry, so leaving that state
    // on a redirect or reset is what invalidates the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            stale_addr <= RESET_PC;
            buf_inst   <= NOP_INST;
            buf_pcadd4 <= 32'd0;
            Inst       <= NOP_INST;
            PCAdd4     <= 32'd0;
            inst_valid <= 1'b0;
        end else if (redirect_valid) begin
            pc         <= word_align(redirect_target);
            Inst       <= NOP_INST;
            inst_valid <= 1'b0;
            case (state)
                ST_FETCH: begin
                    // A completing response is simply dropped; an incomplete
                    // one has to be drained before fetching at the target.
                    if (imem_ready) begin
                        state <= ST_FETCH;
                    end else begin
                        state      <= ST_DISCARD;
                        stale_addr <= pc;
                    end
                end
                ST_DISCARD: begin
                    // Already draining: only PC moves to the newer target.
                    state <= imem_ready ? ST_FETCH : ST_DISCARD;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ready) begin
                        pc <= pc_plus4;
                        if (stall) begin
                            buf_inst   <= imem_rdata;
                            buf_pcadd4 <= pc_plus4;
                            state      <= ST_BUFFERED;
                        end else begin
                            Inst       <= imem_rdata;
                            PCAdd4     <= pc_plus4;
                            inst_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        Inst       <= NOP_INST;
                        inst_valid <= 1'b0;
                    end
                end
                ST_BUFFERED: begin
                    if (!stall) begin
                        Inst       <= buf_inst;
                        PCAdd4     <= buf_pcadd4;
                        inst_valid <= 1'b1;
                        state      <= ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    if (imem_ready) begin
                        state <= ST_FETCH;
                    end
                    if (!stall) begin
                        Inst       <= NOP_INST;
                        inst_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage. A driver issues directed then random
// stimulus at the falling edge and keeps a program-order reference model:
// every instruction accepted on the correct path is pushed to a scoreboard
// queue, a redirect or reset squashes everything not yet presented. A monitor
// samples the IF/ID outputs just after each rising edge and pops/compares.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] MEM_KEY  = 32'hA5A5_A5A5;
    localparam int          RANDOM_CYCLES = 3000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] PCAdd4;
    logic [31:0] Inst;
    logic        inst_valid;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pcadd4;
    } expect_t;

    expect_t     sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model of the program-order fetch stream.
    logic [31:0] model_pc;
    logic        model_drain;
    logic [31:0] model_drain_addr;

    // Previous sampled outputs, for the hold-while-stalled rule.
    logic [31:0] prev_inst;
    logic [31:0] prev_pcadd4;
    logic        prev_valid;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .PCAdd4          (PCAdd4),
        .Inst            (Inst),
        .inst_valid      (inst_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports failures.
    task automatic compare(input string name, input logic [31:0] actual,
                           input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs at the falling edge, then checks the request
    // side against the model and records what the coming edge will accept.
    task automatic applyStimulus(input logic r, input logic s, input logic rv,
                                 input logic [31:0] tgt, input logic rdy);
        logic    req_now;
        expect_t e;
        @(negedge clk);
        rst             = r;
        stall           = s;
        redirect_valid  = rv;
        redirect_target = tgt;
        imem_ready      = rdy;
        #1;
        imem_rdata = imem_addr ^ MEM_KEY;
        req_now    = imem_req;
        if (r) begin
            compare("imem_req_in_reset", {31'd0, req_now}, 32'd0);
            sb_q.delete();
            model_pc    = RESET_PC;
            model_drain = 1'b0;
        end else begin
            compare("imem_req", {31'd0, req_now}, {31'd0, (sb_q.size() == 0)});
            if (req_now) begin
                compare("imem_addr", imem_addr, model_drain ? model_drain_addr : model_pc);
            end
            if (rv) begin
                sb_q.delete();
                if (req_now && !rdy) begin
                    if (!model_drain) model_drain_addr = model_pc;
                    model_drain = 1'b1;
                end else begin
                    model_drain = 1'b0;
                end
                model_pc = tgt & ~32'd3;
            end else if (req_now && rdy) begin
                if (model_drain) begin
                    model_drain = 1'b0;
                end else begin
                    e.inst   = model_pc ^ MEM_KEY;
                    e.pcadd4 = model_pc + 32'd4;
                    sb_q.push_back(e);
                    model_pc = model_pc + 32'd4;
                end
            end
        end
    endtask

    // Checks the IF/ID outputs produced by the edge just taken, using the
    // inputs that were applied for that edge.
    task automatic checkOutput();
        expect_t e;
        if (rst) begin
            compare("reset_inst", Inst, 32'd0);
            compare("reset_pcadd4", PCAdd4, 32'd0);
            compare("reset_valid", {31'd0, inst_valid}, 32'd0);
        end else if (redirect_valid) begin
            compare("redirect_inst", Inst, 32'd0);
            compare("redirect_valid", {31'd0, inst_valid}, 32'd0);
        end else if (stall) begin
            compare("stall_inst", Inst, prev_inst);
            compare("stall_pcadd4", PCAdd4, prev_pcadd4);
            compare("stall_valid", {31'd0, inst_valid}, {31'd0, prev_valid});
        end else if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            compare("present_valid", {31'd0, inst_valid}, 32'd1);
            compare("present_inst", Inst, e.inst);
            compare("present_pcadd4", PCAdd4, e.pcadd4);
        end else begin
            compare("bubble_inst", Inst, 32'd0);
            compare("bubble_valid", {31'd0, inst_valid}, 32'd0);
            compare("bubble_pcadd4", PCAdd4, prev_pcadd4);
        end
        prev_inst   = Inst;
        prev_pcadd4 = PCAdd4;
        prev_valid  = inst_valid;
    endtask

    // Monitor: runs independently of the driver, one check per rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            checkOutput();
        end
    end

    // Driver: directed scenarios first, then a long randomized run.
    initial begin
        logic        r_rst;
        logic        r_stall;
        logic        r_rv;
        logic        r_rdy;
        logic [31:0] r_tgt;
        rst              = 1'b1;
        stall            = 1'b0;
        redirect_valid   = 1'b0;
        redirect_target  = 32'd0;
        imem_ready       = 1'b0;
        imem_rdata       = 32'd0;
        model_pc         = RESET_PC;
        model_drain      = 1'b0;
        model_drain_addr = RESET_PC;

        $display("[TB] reset and zero-wait fetch");
        repeat (3) applyStimulus(1, 0, 0, 32'd0, 0);
        applyStimulus(0, 0, 0, 32'd0, 1);
        $display("[TB] two wait cycles at 0x3004");
        applyStimulus(0, 0, 0, 32'd0, 0);
        applyStimulus(0, 0, 0, 32'd0, 0);
        applyStimulus(0, 0, 0, 32'd0, 1);
        $display("[TB] stall while 0x3008 returns");
        applyStimulus(0, 1, 0, 32'd0, 1);
        applyStimulus(0, 1, 0, 32'd0, 1);
        applyStimulus(0, 1, 0, 32'd0, 1);
        applyStimulus(0, 0, 0, 32'd0, 1);
        applyStimulus(0, 0, 0, 32'd0, 1);
        $display("[TB] redirect to 0x3043 while 0x3010 waits");
        applyStimulus(0, 0, 0, 32'd0, 0);
        applyStimulus(0, 0, 1, 32'h0000_3043, 0);
        applyStimulus(0, 0, 0, 32'd0, 1);
        applyStimulus(0, 0, 0, 32'd0, 1);
        $display("[TB] redirect with stall while buffered");
        applyStimulus(0, 1, 0, 32'd0, 1);
        applyStimulus(0, 1, 1, 32'h0000_5000, 0);
        applyStimulus(0, 0, 0, 32'd0, 1);
        $display("[TB] redirect to 0xFFFFFFFC and wrap");
        applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 1);
        applyStimulus(0, 0, 0, 32'd0, 1);
        applyStimulus(0, 0, 0, 32'd0, 1);
        applyStimulus(0, 0, 0, 32'd0, 0);
        $display("[TB] reset while draining a wrong-path request");
        applyStimulus(0, 0, 1, 32'h0000_7000, 0);
        applyStimulus(1, 0, 0, 32'd0, 1);
        applyStimulus(0, 0, 0, 32'd0, 1);

        $display("[TB] randomized run");
        for (int i = 0; i < RANDOM_CYCLES; i++) begin
            r_rst   = ($urandom_range(0, 99) == 0);
            r_stall = ($urandom_range(0, 3) == 0);
            r_rv    = ($urandom_range(0, 11) == 0);
            r_rdy   = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       r_tgt = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                1:       r_tgt = 32'h0000_3000 + $urandom_range(0, 255);
                default: r_tgt = $urandom;
            endcase
            applyStimulus(r_rst, r_stall, r_rv, r_tgt, r_rdy);
        end
        repeat (4) applyStimulus(0, 0, 0, 32'd0, 1);
        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
